// File: rtl/temporizador_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | temporizador_pkg: shared state encoding and channel-search helpers   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package temporizador_pkg;

   localparam int MAX_CH    = 64;
   localparam int MAX_IDX_W = 6;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic                 valid;
      logic [MAX_IDX_W-1:0] idx;
   } nn_t;

   // Width of the cur_ch port for a given channel count (never below 1).
   function automatic int ch_idx_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   // Lowest channel at or above from_index whose duration is nonzero.
   function automatic nn_t next_nonzero(input logic [MAX_CH-1:0] nz_vec,
                                        input int from_index);
      nn_t r;
      r = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (nz_vec[i] && (i >= from_index)) begin
            r.valid = 1'b1;
            r.idx   = MAX_IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | divisor_tick: one-cycle tick every UNIT_CYCLES enabled cycles        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module divisor_tick #(
   parameter int UNIT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = en && !clear && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/temporizador_multicanal.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | temporizador_multicanal: sequential per-channel motor timer          |
// | Optional pause input under macro TEMPORIZADOR_PAUSE_EN. Rev 1.0      |
// +----------------------------------------------------------------------+
module temporizador_multicanal
   import temporizador_pkg::*;
#(
   parameter int N_CH        = 3,
   parameter int DUR_W       = 5,
   parameter int UNIT_CYCLES = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_CH*DUR_W-1:0]       dur,
   input  logic                        abort,
   output logic                        busy,
   output logic [N_CH-1:0]             ch_on,
   output logic [ch_idx_w(N_CH)-1:0]   cur_ch,
   output logic [N_CH-1:0]             ch_done,
   output logic                        done
`ifdef TEMPORIZADOR_PAUSE_EN
   ,
   input  logic                        pause
`endif
);

   localparam int CH_W = ch_idx_w(N_CH);

   state_t                  state_q, state_d;
   logic [N_CH*DUR_W-1:0]   dur_q, dur_d;
   logic [DUR_W-1:0]        unit_q, unit_d;
   logic [CH_W-1:0]         cur_q, cur_d;
   logic                    busy_q, busy_d;
   logic [N_CH-1:0]         ch_on_q, ch_on_d;
   logic [N_CH-1:0]         ch_done_q, ch_done_d;
   logic                    done_q, done_d;

   logic                    pause_w;
   logic                    tick;
   logic                    div_clear;
   logic                    div_en;
   logic                    accept;
   logic                    chan_last;
   logic [DUR_W-1:0]        cur_dur;
   logic [MAX_CH-1:0]       nz_in;
   logic [MAX_CH-1:0]       nz_cap;
   nn_t                     first_nn;
   nn_t                     next_nn;

`ifdef TEMPORIZADOR_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   for (genvar g = 0; g < MAX_CH; g++) begin : g_nz
      if (g < N_CH) begin : g_used
         assign nz_in[g]  = |dur[g*DUR_W +: DUR_W];
         assign nz_cap[g] = |dur_q[g*DUR_W +: DUR_W];
      end else begin : g_pad
         assign nz_in[g]  = 1'b0;
         assign nz_cap[g] = 1'b0;
      end
   end

   assign first_nn  = next_nonzero(nz_in, 0);
   assign next_nn   = next_nonzero(nz_cap, int'(cur_q) + 1);
   assign cur_dur   = dur_q[int'(cur_q)*DUR_W +: DUR_W];

   // abort in IDLE suppresses a simultaneous start.
   assign accept    = (state_q == ST_IDLE) && start && !abort;
   assign div_clear = (state_q != ST_RUN) || abort;
   assign div_en    = (state_q == ST_RUN) && !pause_w;
   // cur_dur is never zero in RUN, so the decrement cannot wrap.
   assign chan_last = tick && (unit_q == cur_dur - DUR_W'(1));

   divisor_tick #(
      .UNIT_CYCLES (UNIT_CYCLES)
   ) u_divisor_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (div_clear),
      .en    (div_en),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         dur_q     <= '0;
         unit_q    <= '0;
         cur_q     <= '0;
         busy_q    <= 1'b0;
         ch_on_q   <= '0;
         ch_done_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dur_q     <= dur_d;
         unit_q    <= unit_d;
         cur_q     <= cur_d;
         busy_q    <= busy_d;
         ch_on_q   <= ch_on_d;
         ch_done_q <= ch_done_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && first_nn.valid) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort || (chan_last && !next_nn.valid)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dur_d     = dur_q;
      unit_d    = unit_q;
      cur_d     = cur_q;
      busy_d    = busy_q;
      ch_on_d   = ch_on_q;
      ch_done_d = '0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_d  = 1'b0;
            ch_on_d = '0;
            cur_d   = '0;
            unit_d  = '0;
            if (accept) begin
               dur_d = dur;
               if (first_nn.valid) begin
                  busy_d  = 1'b1;
                  cur_d   = CH_W'(first_nn.idx);
                  ch_on_d = N_CH'(1) << first_nn.idx;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               busy_d  = 1'b0;
               ch_on_d = '0;
               cur_d   = '0;
               unit_d  = '0;
            end else if (chan_last) begin
               ch_done_d = N_CH'(1) << cur_q;
               unit_d    = '0;
               if (next_nn.valid) begin
                  cur_d   = CH_W'(next_nn.idx);
                  ch_on_d = N_CH'(1) << next_nn.idx;
               end else begin
                  busy_d  = 1'b0;
                  ch_on_d = '0;
                  cur_d   = '0;
                  done_d  = 1'b1;
               end
            end else begin
               if (tick) begin
                  unit_d = unit_q + DUR_W'(1);
               end
               // A paused edge blanks the motor for the following cycle only.
               ch_on_d = pause_w ? '0 : (N_CH'(1) << cur_q);
            end
         end
         default: ;
      endcase
   end

   assign busy    = busy_q;
   assign ch_on   = ch_on_q;
   assign cur_ch  = cur_q;
   assign ch_done = ch_done_q;
   assign done    = done_q;

endmodule
`default_nettype wire
